// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage and decode: bus widths, reset PC and opcodes.
// Opcodes sit in the top byte of each instruction word.
package fetch_unit_pkg;

   localparam int          DEF_BITS_DATA = 32;
   localparam int          DEF_BITS_ADDR = 16;
   localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
   localparam int          DEF_DEPTH     = 4;

   localparam logic [7:0] OPD_NOP = 8'h00;
   localparam logic [7:0] OPD_LD  = 8'h09;
   localparam logic [7:0] OPD_STR = 8'h0B;
   localparam logic [7:0] OPD_ADD = 8'hA6;
   localparam logic [7:0] OPD_SUB = 8'hB2;
   localparam logic [7:0] OPD_MUL = 8'hB8;
   localparam logic [7:0] OPD_JMP = 8'hD1;
   localparam logic [7:0] OPD_JZ  = 8'hF1;

   typedef enum logic [7:0] {
      OP_NOP = 8'h00,
      OP_LD  = 8'h09,
      OP_STR = 8'h0B,
      OP_ADD = 8'hA6,
      OP_SUB = 8'hB2,
      OP_MUL = 8'hB8,
      OP_JMP = 8'hD1,
      OP_JZ  = 8'hF1
   } opcode_e;

   typedef struct packed {
      logic [DEF_BITS_ADDR-1:0] pc;
      logic [DEF_BITS_DATA-1:0] word;
   } fetch_entry_t;

   function automatic logic [7:0] opcode_of(input logic [DEF_BITS_DATA-1:0] word);
      return word[DEF_BITS_DATA-1 -: 8];
   endfunction

   function automatic logic is_branch(input logic [DEF_BITS_DATA-1:0] word);
      return (opcode_of(word) == OPD_JMP) || (opcode_of(word) == OPD_JZ);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, word} pairs with wrapping pointers and a flush that
// overrides any push or pop in the same cycle.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int BITS_DATA = DEF_BITS_DATA,
   parameter int BITS_ADDR = DEF_BITS_ADDR
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush_i,
   input  logic                 push_i,
   input  logic [BITS_ADDR-1:0] push_pc_i,
   input  logic [BITS_DATA-1:0] push_word_i,
   input  logic                 pop_i,
   output logic                 head_valid_o,
   output logic [BITS_ADDR-1:0] head_pc_o,
   output logic [BITS_DATA-1:0] head_word_o,
   output logic                 full_o
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [PTR_W:0]       count_q, count_d;
   logic [BITS_ADDR-1:0] pc_mem_q   [DEPTH];
   logic [BITS_DATA-1:0] word_mem_q [DEPTH];
   logic                 push_ok;
   logic                 pop_ok;

   // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
   assign full_o       = (count_q == FULL_CNT);
   assign head_valid_o = (count_q != '0);
   assign push_ok      = push_i && !full_o && !flush_i;
   assign pop_ok       = pop_i && head_valid_o && !flush_i;
   assign head_pc_o    = pc_mem_q[head_q];
   assign head_word_o  = word_mem_q[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) tail_d = tail_q + 1'b1;
         if (pop_ok)  head_d = head_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem_q[tail_q]   <= push_pc_i;
         word_mem_q[tail_q] <= push_word_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the single memory port, prefetches sequential words
// into a small queue, yields the port to execute data accesses, and handles redirects.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                   BITS_DATA = DEF_BITS_DATA,
   parameter int                   BITS_ADDR = DEF_BITS_ADDR,
   parameter int                   DEPTH     = DEF_DEPTH,
   parameter logic [BITS_ADDR-1:0] RESET_PC  = BITS_ADDR'(DEF_RESET_PC)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic [BITS_ADDR-1:0] mem_address,
   output logic [BITS_DATA-1:0] mem_data_in,
   output logic                 mem_write,
   input  logic [BITS_DATA-1:0] mem_data_out,
   output logic                 inst_valid,
   output logic [BITS_DATA-1:0] inst_data,
   output logic [BITS_ADDR-1:0] inst_pc,
   input  logic                 inst_ready,
   input  logic                 redirect_valid,
   input  logic [BITS_ADDR-1:0] redirect_pc,
   input  logic                 dreq,
   input  logic                 dwrite,
   input  logic [BITS_ADDR-1:0] daddr,
   input  logic [BITS_DATA-1:0] dwdata,
   output logic [BITS_DATA-1:0] drdata,
   output logic                 fetch_stall
);

   logic [BITS_ADDR-1:0] pc_q, pc_d;
   logic                 queue_full;
   logic                 fetch_go;

   // Execute owns the port whenever it asks; fetch only ever reads.
   always_comb begin
      if (dreq) begin
         mem_address = daddr;
         mem_data_in = dwdata;
         mem_write   = dwrite;
      end else begin
         mem_address = pc_q;
         mem_data_in = '0;
         mem_write   = 1'b0;
      end
   end

   assign drdata      = mem_data_out;
   assign fetch_go    = !dreq && !redirect_valid && !queue_full;
   assign fetch_stall = reset_n && (dreq || queue_full);

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid)
         pc_d = redirect_pc;
      else if (fetch_go)
         pc_d = pc_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   fetch_queue #(
      .DEPTH     (DEPTH),
      .BITS_DATA (BITS_DATA),
      .BITS_ADDR (BITS_ADDR)
   ) u_queue (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush_i      (redirect_valid),
      .push_i       (fetch_go),
      .push_pc_i    (pc_q),
      .push_word_i  (mem_data_out),
      .pop_i        (inst_ready),
      .head_valid_o (inst_valid),
      .head_pc_o    (inst_pc),
      .head_word_o  (inst_data),
      .full_o       (queue_full)
   );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the 32-bit/16-bit-address single-port data memory. Owns the memory's address/data_in/write pins, streams sequential instruction words into a small prefetch queue toward decode, and gives load/store requests from execute priority on the shared port. Supports PC redirect for JMP/JZ with queue flush.

## Interface
- BITS_DATA, 32, word width
- BITS_ADDR, 16, address width / PC width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset

- clk  in  1  system clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- mem_address  out  BITS_ADDR  to memory address
- mem_data_in  out  BITS_DATA  to memory data_in
- mem_write  out  1  to memory write
- mem_data_out  in  BITS_DATA  memory asynchronous read data
- inst_valid  out  1  queue head valid
- inst_data  out  BITS_DATA  head instruction word
- inst_pc  out  BITS_ADDR  address of head word
- inst_ready  in  1  decode accepts head this cycle
- redirect_valid  in  1  jump taken; flush and refetch
- redirect_pc  in  BITS_ADDR  jump target
- dreq  in  1  execute data access request
- dwrite  in  1  data access is store (qualified by dreq)
- daddr  in  BITS_ADDR  data address
- dwdata  in  BITS_DATA  store data
- drdata  out  BITS_DATA  load data, = mem_data_out, valid same cycle as dreq
- fetch_stall  out  1  high in any cycle fetch lost the port (dreq or full)

## Operation
- Port mux (combinational): dreq=1 → mem_address=daddr, mem_data_in=dwdata, mem_write=dwrite; else mem_address=pc, mem_data_in=0, mem_write=0. Fetch never writes.
- Fetch cycle: dreq=0, redirect_valid=0, count<DEPTH → at posedge push {pc, mem_data_out} to tail, pc←pc+1 (16-bit wrap, 0xFFFF→0x0000).
- Pop: inst_valid && inst_ready → head advances at posedge.
- Full: count==DEPTH blocks push even if pop occurs same cycle (count uses registered value); push+pop when not full leaves count unchanged.
- Redirect: at posedge queue cleared (count←0, pointers←0), pc←redirect_pc; any fetch or pop that cycle discarded. Redirect wins over dreq for PC update; dreq access itself still executes on the port.
- Store of an address already prefetched is not snooped; execute issues redirect to refetch if required.
- Reset (async, any time, including mid-flush): pc←RESET_PC, count←0, pointers←0; inst_valid=0, fetch_stall=0 while reset_n=0, mem_write=dwrite&dreq (combinational).

## Timing
- Memory read is asynchronous: fetch word captured at the posedge ending the cycle pc is driven; inst_valid rises one cycle after first fetch cycle.
- First instruction visible in cycle 1 after reset_n deassertion (cycle 0 fetches RESET_PC).
- Sustained throughput 1 word/cycle with inst_ready=1 and dreq=0.
- Store completes at the memory's negedge within the dreq cycle; load data on drdata same cycle, no registered latency.
- After redirect: inst_valid=0 next cycle; target word valid the cycle after.

## Structure
- Shared package: BITS_DATA, BITS_ADDR, RESET_PC defaults, opcode constants (OPD_NOP 8'h00, OPD_LD 8'h09, OPD_STR 8'h0B, OPD_ADD 8'hA6, OPD_SUB 8'hB2, OPD_MUL 8'hB8, OPD_JMP 8'hD1, OPD_JZ 8'hF1) for decode reuse.
- One sub-module: fetch_queue (DEPTH-entry FIFO of {pc, word}, flush input, count/wrapping pointers).

## Test plan
- Reset, memory preloaded with test program, inst_ready=1 → inst sequence pc0:0x00000000, pc1:0x0900000C, pc2:0x09010001, … one per cycle.
- inst_ready=0 for 8 cycles → exactly 4 entries, fetch_stall=1, pc holds at 4; release → pcs 0..4 in order, no duplicate/gap.
- redirect_valid with redirect_pc=0x0004 while queue holds 3 entries → next cycle inst_valid=0, following cycle inst_pc=4, inst_data=0x09030002.
- dreq=1, dwrite=1, daddr=0x1000, dwdata=0x00000001 for one cycle mid-stream → memory[0x1000]=1, pc unchanged that cycle, stream resumes; then dreq load 0x1000 → drdata=1 same cycle.
- pc=0xFFFF fetch → next inst_pc=0x0000.
- reset_n low mid-stream with full queue → inst_valid=0 immediately; after release fetch restarts at 0x0000.
